// File: rtl/poly_pkg.sv
// Shared constants and helpers for the polynomial add/subtract datapath.
//   DefN / DefQ   : default coefficient width and modulus
//   MODE_ADD/SUB  : per-polynomial operation encoding
//   lane_slice()  : extract lane `lane` of `width` bits from a packed lane vector
package poly_pkg;

  localparam int unsigned DefN = 16;
  localparam int unsigned DefQ = 12289;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Upper bounds for the slicing helper; callers zero-extend into MaxVecW.
  localparam int unsigned MaxVecW  = 1024;
  localparam int unsigned MaxLaneW = 64;

  function automatic logic [MaxLaneW-1:0] lane_slice(input logic [MaxVecW-1:0] vec,
                                                     input int unsigned       lane,
                                                     input int unsigned       width);
    logic [MaxVecW-1:0]  sh;
    logic [MaxLaneW-1:0] mask;
    sh   = vec >> (lane * width);
    mask = (MaxLaneW'(1) << width) - MaxLaneW'(1);
    return sh[MaxLaneW-1:0] & mask;
  endfunction

endpackage

// File: rtl/modaddsub_lane.sv
// One coefficient lane of the modular add/subtract pipeline.
//   clk, rst : clock, synchronous active-high reset
//   en1      : load stage 1 (raw sum/difference and this beat's mode)
//   en2      : load stage 2 (corrected result)
//   mode     : MODE_ADD / MODE_SUB for the beat entering stage 1
//   a, b     : N-bit operands
//   s        : registered (a +/- b) mod Q
module modaddsub_lane
  import poly_pkg::*;
#(
  parameter int unsigned N = DefN,
  parameter int unsigned Q = DefQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en1,
  input  logic         en2,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s
);

  localparam logic [N:0] QW = (N+1)'(Q);

  logic [N:0]   raw_d, raw_q;
  logic         mode_q;
  logic [N:0]   diff;
  logic [N-1:0] s_d, s_q;

  // Bit N is the carry for add, the borrow for subtract.
  always_comb begin
    raw_d = '0;
    if (mode == MODE_SUB) begin
      raw_d = {1'b0, a} - {1'b0, b};
    end else begin
      raw_d = {1'b0, a} + {1'b0, b};
    end
  end

  always_comb begin
    s_d  = raw_q[N-1:0];
    diff = raw_q - QW;
    if (mode_q == MODE_SUB) begin
      if (raw_q[N]) begin
        s_d = raw_q[N-1:0] + QW[N-1:0];
      end
    end else if (raw_q >= QW) begin
      s_d = diff[N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q  <= '0;
      mode_q <= MODE_ADD;
      s_q    <= '0;
    end else begin
      if (en1) begin
        raw_q  <= raw_d;
        mode_q <= mode;
      end
      if (en2) begin
        s_q <= s_d;
      end
    end
  end

  assign s = s_q;

endmodule

// File: rtl/poly_addsub_pipe.sv
// Streaming two-stage modular add/subtract of two polynomials, L lanes per beat.
//   clk, rst            : clock, synchronous active-high reset
//   mode                : 0 = a+b, 1 = a-b; taken from the first beat of each polynomial
//   in_valid / in_ready : input beat handshake
//   a, b                : L packed N-bit coefficients (lane i at [(i+1)*N-1:i*N])
//   out_valid/out_ready : output beat handshake
//   s                   : L packed results (a +/- b) mod Q
//   out_idx, out_last   : beat index within the polynomial, high on final beat
//   err_range           : sticky flag, some accepted coefficient was >= Q
module poly_addsub_pipe
  import poly_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned Q  = DefQ,
  parameter int unsigned D  = 256,
  parameter int unsigned L  = 4,
  parameter int unsigned IW = $clog2(D / L)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [L*N-1:0] a,
  input  logic [L*N-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [L*N-1:0] s,
  output logic [IW-1:0]  out_idx,
  output logic           out_last,
  output logic           err_range
);

  localparam int unsigned Beats   = D / L;
  localparam logic [IW-1:0] LastIdx = IW'(Beats - 1);
  localparam logic [N-1:0]  QN      = N'(Q);

  logic          s1_valid_q, s2_valid_q;
  logic [IW-1:0] cnt_q, idx1_q, idx2_q;
  logic          mode_q, err_q;
  logic          adv1, adv2, accept, load2, beat_mode;
  logic [L-1:0]  lane_bad;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && adv1;
  assign load2    = adv2 && s1_valid_q;

  // The first beat of a polynomial uses the live mode input; later beats the latched one.
  assign beat_mode = (cnt_q == '0) ? mode : mode_q;

  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    logic [N-1:0] a_l, b_l;

    assign a_l          = N'(lane_slice(MaxVecW'(a), gi, N));
    assign b_l          = N'(lane_slice(MaxVecW'(b), gi, N));
    assign lane_bad[gi] = (a_l >= QN) || (b_l >= QN);

    modaddsub_lane #(
      .N (N),
      .Q (Q)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en1  (accept),
      .en2  (load2),
      .mode (beat_mode),
      .a    (a_l),
      .b    (b_l),
      .s    (s[gi*N +: N])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
      idx1_q     <= '0;
      idx2_q     <= '0;
      mode_q     <= MODE_ADD;
      err_q      <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_q <= accept;
      end
      if (accept) begin
        idx1_q <= cnt_q;
        cnt_q  <= (cnt_q == LastIdx) ? '0 : cnt_q + IW'(1);
        if (cnt_q == '0) begin
          mode_q <= mode;
        end
        if (|lane_bad) begin
          err_q <= 1'b1;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
      end
      if (load2) begin
        idx2_q <= idx1_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_idx   = idx2_q;
  assign out_last  = (idx2_q == LastIdx);
  assign err_range = err_q;

endmodule

// File: tb/tb_poly_addsub_pipe.sv
module tb_poly_addsub_pipe;

  localparam int N     = 16;
  localparam int Q     = 12289;
  localparam int D     = 256;
  localparam int L     = 4;
  localparam int IW    = 6;
  localparam int W     = L * N;
  localparam int BEATS = D / L;

  logic          clk = 1'b0;
  logic          rst, mode, in_valid, in_ready, out_valid, out_ready, out_last, err_range;
  logic [W-1:0]  a, b, s;
  logic [IW-1:0] out_idx;

  poly_addsub_pipe #(
    .N  (N),
    .Q  (Q),
    .D  (D),
    .L  (L),
    .IW (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    int           idx;
    bit           chk;
  } exp_t;

  exp_t exp_q[$];
  int   exp_cnt;
  logic exp_mode;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_acc;

  // Reference: per-lane modular arithmetic on integers.
  function automatic logic [W-1:0] model_s(logic [W-1:0] av, logic [W-1:0] bv, logic m);
    logic [W-1:0] r;
    int ai, bi, x;
    r = '0;
    for (int i = 0; i < L; i++) begin
      ai = int'(av[i*N +: N]);
      bi = int'(bv[i*N +: N]);
      x  = m ? (ai - bi + Q) % Q : (ai + bi) % Q;
      r[i*N +: N] = x[N-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pack4(int v0, int v1, int v2, int v3);
    logic [W-1:0] r;
    r = {v3[N-1:0], v2[N-1:0], v1[N-1:0], v0[N-1:0]};
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    return pack4($urandom_range(Q - 1), $urandom_range(Q - 1),
                 $urandom_range(Q - 1), $urandom_range(Q - 1));
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); exp_cnt = 0; exp_mode = 1'b0;
  endtask

  // Present one beat until accepted; records the expected result in the model.
  task automatic drive_beat(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m,
                            output bit ok);
    exp_t e;
    bit   in_rng;
    in_valid = 1'b1; a = av; b = bv; mode = m; ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (ok) begin
      if (exp_cnt == 0) exp_mode = m;
      in_rng = 1;
      for (int i = 0; i < L; i++)
        if (int'(av[i*N +: N]) >= Q || int'(bv[i*N +: N]) >= Q) in_rng = 0;
      e.s = model_s(av, bv, exp_mode); e.idx = exp_cnt; e.chk = in_rng;
      exp_q.push_back(e);
      exp_cnt = (exp_cnt + 1) % BEATS;
      n_acc++;
    end
  endtask

  // Wait for the next output transfer; `waited` counts the negedges spent.
  task automatic get_beat(output logic [W-1:0] sv, output int iv, output logic lv,
                          output int waited, output bit ok);
    ok = 0; waited = 0; sv = '0; iv = -1; lv = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      waited++;
      if (out_valid && out_ready) begin
        sv = s; iv = int'(out_idx); lv = out_last; ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b1; in_valid = 1'b1; a = rand_vec(); b = rand_vec(); mode = 1'b1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete(); exp_cnt = 0; exp_mode = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (s !== '0) $display("FAIL reset_s: got %h want 0", s); else n_pass++;
    n_checks++; if (out_idx !== '0) $display("FAIL reset_idx: got %0d want 0", out_idx); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", out_last); else n_pass++;
    n_checks++; if (err_range !== 1'b0) $display("FAIL reset_err: got %b want 0", err_range); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_single(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [W-1:0] want, input string nm);
    bit ok;
    do_reset();
    out_ready = 1'b1;
    drive_beat(av, bv, m, ok);
    n_checks++; if (!ok) $display("FAIL %s_accept: got 0 want 1", nm); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL %s_latency1: got %b want 0", nm, out_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL %s_latency2: got %b want 1", nm, out_valid); else n_pass++;
    n_checks++; if (s !== want) $display("FAIL %s_s: got %h want %h", nm, s, want); else n_pass++;
    n_checks++; if (out_idx !== '0) $display("FAIL %s_idx: got %0d want 0", nm, out_idx); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_full_poly();
    logic m0;
    do_reset();
    out_ready = 1'b1; n_acc = 0; m0 = 1'($urandom_range(1));
    fork
      begin
        bit ok;
        for (int k = 0; k < 2 * BEATS; k++) drive_beat(rand_vec(), rand_vec(), (k < BEATS) ? m0 : !m0, ok);
      end
      begin
        logic [W-1:0] sv; int iv, w; logic lv; bit ok; exp_t e; int errs;
        errs = 0;
        for (int k = 0; k < 2 * BEATS; k++) begin
          get_beat(sv, iv, lv, w, ok);
          if (!ok || exp_q.size() == 0) begin
            $display("FAIL full_timeout: got no beat want beat %0d", k); errs++;
            break;
          end
          e = exp_q.pop_front();
          if (sv !== e.s || iv != e.idx || iv != k % BEATS || lv !== (iv == BEATS - 1)) begin
            $display("FAIL full_beat: got s=%h idx=%0d last=%b want s=%h idx=%0d", sv, iv, lv, e.s, k % BEATS);
            errs++;
          end
          if (k > 0 && w != 1) begin
            $display("FAIL full_bubble: got gap %0d want 1 at beat %0d", w, k); errs++;
          end
        end
        n_checks++; if (errs != 0) $display("FAIL full_poly: got %0d bad beats want 0", errs); else n_pass++;
      end
    join
    n_checks++; if (n_acc != 2 * BEATS) $display("FAIL full_accepts: got %0d want %0d", n_acc, 2 * BEATS); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    n_acc = 0; out_ready = 1'b0;
    fork
      begin
        bit ok;
        for (int k = 0; k < 8; k++) drive_beat(rand_vec(), rand_vec(), 1'b1, ok);
      end
      begin
        logic [W-1:0] held, sv; int held_idx, iv, w; logic lv; bit ok; exp_t e; int errs;
        held = '0; held_idx = 0; errs = 0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (c == 2) begin
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
            n_checks++; if (n_acc != 2) $display("FAIL bp_accepted: got %0d want 2", n_acc); else n_pass++;
            n_checks++; if (out_valid !== 1'b1 || out_idx !== '0) $display("FAIL bp_head: got v=%b idx=%0d want v=1 idx=0", out_valid, out_idx); else n_pass++;
            held = s; held_idx = int'(out_idx);
          end else if (c > 2) begin
            n_checks++;
            if (s !== held || int'(out_idx) != held_idx || in_ready !== 1'b0 || n_acc != 2)
              $display("FAIL bp_stable: got s=%h idx=%0d acc=%0d want s=%h idx=%0d acc=2", s, out_idx, n_acc, held, held_idx);
            else n_pass++;
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
          get_beat(sv, iv, lv, w, ok);
          if (!ok || exp_q.size() == 0) begin
            $display("FAIL bp_timeout: got no beat want beat %0d", k); errs++;
            break;
          end
          e = exp_q.pop_front();
          if (sv !== e.s || iv != k) begin
            $display("FAIL bp_beat: got s=%h idx=%0d want s=%h idx=%0d", sv, iv, e.s, k); errs++;
          end
        end
        n_checks++; if (errs != 0 || n_acc != 8) $display("FAIL bp_drain: got %0d bad, %0d accepted want 0, 8", errs, n_acc); else n_pass++;
      end
    join
  endtask

  task automatic test_mode_toggle();
    do_reset();
    out_ready = 1'b1;
    fork
      begin
        bit ok;
        for (int k = 0; k < BEATS; k++) drive_beat(rand_vec(), rand_vec(), (k < 5) ? 1'b0 : 1'b1, ok);
      end
      begin
        logic [W-1:0] sv; int iv, w; logic lv; bit ok; exp_t e; int errs;
        errs = 0;
        for (int k = 0; k < BEATS; k++) begin
          get_beat(sv, iv, lv, w, ok);
          if (!ok || exp_q.size() == 0) begin
            $display("FAIL toggle_timeout: got no beat want beat %0d", k); errs++;
            break;
          end
          e = exp_q.pop_front();
          if (sv !== e.s) begin
            $display("FAIL toggle_beat: got s=%h want s=%h (add) at idx %0d", sv, e.s, iv); errs++;
          end
        end
        n_checks++; if (errs != 0) $display("FAIL mode_toggle: got %0d bad beats want 0", errs); else n_pass++;
      end
    join
  endtask

  task automatic test_err_reset();
    logic [W-1:0] av;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      av = rand_vec();
      if (k == 3) begin
        av[N +: N] = 16'd12289;
        n_checks++; if (err_range !== 1'b0) $display("FAIL err_before: got %b want 0", err_range); else n_pass++;
      end
      drive_beat(av, rand_vec(), 1'b0, ok);
      if (k == 3) begin
        n_checks++; if (err_range !== 1'b1) $display("FAIL err_set: got %b want 1", err_range); else n_pass++;
      end
    end
    n_checks++; if (err_range !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_range); else n_pass++;
    do_reset();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (err_range !== 1'b0) $display("FAIL rst_mid_err: got %b want 0", err_range); else n_pass++;
    fork
      begin
        bit ok2;
        drive_beat(rand_vec(), rand_vec(), 1'b1, ok2);
      end
      begin
        logic [W-1:0] sv; int iv, w; logic lv; bit ok3; exp_t e;
        get_beat(sv, iv, lv, w, ok3);
        e.s = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        n_checks++;
        if (!ok3 || iv != 0 || sv !== e.s) $display("FAIL rst_mid_next: got ok=%b idx=%0d s=%h want idx=0 s=%h", ok3, iv, sv, e.s);
        else n_pass++;
      end
    join
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    exp_cnt = 0; exp_mode = 1'b0; n_acc = 0;
    test_reset();
    test_single(1'b0, pack4(12288, 1, 6000, 0), pack4(1, 2, 7000, 0), pack4(0, 3, 711, 0), "add1");
    test_single(1'b1, pack4(0, 5, 12288, 100), pack4(1, 5, 0, 200), pack4(12288, 0, 12288, 12189), "sub1");
    test_full_poly();
    test_backpressure();
    test_mode_toggle();
    test_err_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
